instruction_sequencer: RTL



---
 rtl/instruction_sequencer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/instruction_sequencer.sv
// Program buffer and fetch sequencer feeding the cpu's current_instruction input.
// A host loads words into the internal program memory while the sequencer is
// IDLE or HALTED. start_in begins fetching at start_address_in. The sequencer
// then issues one instruction per clock until it reads a HALT opcode or sees
// stop_in. NOP_INSTRUCTION is driven whenever it is not running.
//
// Ports:
//   clock_in                 system clock, rising edge
//   reset_in                 synchronous active-high reset (memory is not cleared)
//   load_enable_in           write load_data_in to load_address_in (IDLE/HALTED only)
//   load_address_in          program write address
//   load_data_in             program word
//   start_in                 begin execution at start_address_in
//   start_address_in         first fetch address
//   stop_in                  abort a running program
//   current_instruction_out  registered instruction to the cpu
//   program_counter_out      address of the word on current_instruction_out
//   busy_out                 high while in RUN
//   done_out                 one-cycle pulse when HALT is reached
//   instruction_count_out    instructions issued since last start, saturating
module instruction_sequencer #(
    parameter int          ADDR_WIDTH      = 6,
    parameter logic [31:0] NOP_INSTRUCTION = 32'h0000_0005,
    parameter logic [7:0]  HALT_OPCODE     = 8'hFF
) (
    input  logic                  clock_in,
    input  logic                  reset_in,
    input  logic                  load_enable_in,
    input  logic [ADDR_WIDTH-1:0] load_address_in,
    input  logic [31:0]           load_data_in,
    input  logic                  start_in,
    input  logic [ADDR_WIDTH-1:0] start_address_in,
    input  logic                  stop_in,
    output logic [31:0]           current_instruction_out,
    output logic [ADDR_WIDTH-1:0] program_counter_out,
    output logic                  busy_out,
    output logic                  done_out,
    output logic [15:0]           instruction_count_out
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

    state_t                state, state_next;
    logic [31:0]           instruction_next;
    logic [ADDR_WIDTH-1:0] pc_next;
    logic [ADDR_WIDTH-1:0] pc_inc;
    logic                  done_next;
    logic [15:0]           count_next;
    logic [31:0]           fetch_word;

    logic [31:0] mem [0:DEPTH-1];

    // Writes land at the clock edge, so a same-cycle fetch of the same address
    // sees the old contents through the combinational read below.
    always_ff @(posedge clock_in) begin
        if (load_enable_in && state != RUN)
            mem[load_address_in] <= load_data_in;
    end

    // Natural ADDR_WIDTH overflow gives the wrap from the last address to 0.
    assign pc_inc     = program_counter_out + ADDR_WIDTH'(1);
    assign fetch_word = (state == RUN) ? mem[pc_inc] : mem[start_address_in];

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state                   <= IDLE;
            current_instruction_out <= NOP_INSTRUCTION;
            program_counter_out     <= '0;
            busy_out                <= 1'b0;
            done_out                <= 1'b0;
            instruction_count_out   <= '0;
        end else begin
            state                   <= state_next;
            current_instruction_out <= instruction_next;
            program_counter_out     <= pc_next;
            busy_out                <= (state_next == RUN);
            done_out                <= done_next;
            instruction_count_out   <= count_next;
        end
    end

    always_comb begin
        state_next       = state;
        instruction_next = NOP_INSTRUCTION;
        pc_next          = program_counter_out;
        done_next        = 1'b0;
        count_next       = instruction_count_out;
        case (state)
            RUN: begin
                if (stop_in) begin
                    state_next = HALTED;
                end else if (fetch_word[7:0] == HALT_OPCODE) begin
                    state_next = HALTED;
                    pc_next    = pc_inc;
                    done_next  = 1'b1;
                end else begin
                    instruction_next = fetch_word;
                    pc_next          = pc_inc;
                    if (instruction_count_out != 16'hFFFF)
                        count_next = instruction_count_out + 16'd1;
                end
            end
            default: begin
                // IDLE and HALTED: start_in wins over stop_in, which is ignored here.
                if (start_in) begin
                    pc_next = start_address_in;
                    if (fetch_word[7:0] == HALT_OPCODE) begin
                        state_next = HALTED;
                        done_next  = 1'b1;
                        count_next = 16'd0;
                    end else begin
                        state_next       = RUN;
                        instruction_next = fetch_word;
                        count_next       = 16'd1;
                    end
                end
            end
        endcase
    end

endmodule
